// File: rtl/mul_issue_ctrl.sv
// Requester-side front end for the handshake multiplier: accepts M-extension ops,
// drives the multiplier request, selects the result word and hands it to writeback.
module mul_issue_ctrl #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned TAG_W = 5,
    parameter int unsigned WDOG  = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_src1,
    input  logic [XLEN-1:0]  in_src2,
    input  logic [TAG_W-1:0] in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_data,
    output logic [TAG_W-1:0] out_rd,
    output logic             err,
    output logic             m_flush,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_mulw,
    output logic [1:0]       m_signed,
    output logic [XLEN-1:0]  m_multiplicand,
    output logic [XLEN-1:0]  m_multiplier,
    input  logic             m_out_valid,
    input  logic [XLEN-1:0]  m_hi,
    input  logic [XLEN-1:0]  m_lo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_MULW   = 3'd4;

    localparam int unsigned   WD_W   = (WDOG > 0) ? $clog2(WDOG + 1) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(WDOG);

    state_t            state, state_nx;
    logic [XLEN-1:0]   src1_q, src2_q, data_q;
    logic [2:0]        op_q;
    logic [TAG_W-1:0]  rd_q, out_rd_q;
    logic [WD_W-1:0]   wd_cnt;
    logic              err_q;
    logic [XLEN-1:0]   result_sel;
    logic              accept;

    assign in_ready       = (state == S_IDLE) && !flush && !rst;
    assign accept         = in_valid && in_ready;
    assign m_flush        = flush;
    assign m_valid        = (state == S_REQ);
    assign out_valid      = (state == S_DONE);
    assign out_data       = data_q;
    assign out_rd         = out_rd_q;
    assign err            = err_q;
    assign m_multiplicand = src1_q;
    assign m_multiplier   = src2_q;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept)      state_nx = S_REQ;
            S_REQ:   if (m_ready)     state_nx = S_WAIT;
            S_WAIT:  if (m_out_valid) state_nx = S_DONE;
            S_DONE:  if (out_ready)   state_nx = S_IDLE;
            default:                  state_nx = S_IDLE;
        endcase
        if (flush) state_nx = S_IDLE;
    end

    // Reserved opcodes fall through to the MUL defaults in both decoders.
    always_comb begin
        m_signed = 2'b11;
        m_mulw   = 1'b0;
        case (op_q)
            OP_MULHSU: m_signed = 2'b10;
            OP_MULHU:  m_signed = 2'b00;
            OP_MULW:   m_mulw   = 1'b1;
            default:   ;
        endcase
    end

    always_comb begin
        result_sel = m_lo;
        case (op_q)
            OP_MULH, OP_MULHSU, OP_MULHU: result_sel = m_hi;
            OP_MULW: result_sel = {{(XLEN-32){m_lo[31]}}, m_lo[31:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            src1_q   <= '0;
            src2_q   <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            data_q   <= '0;
            out_rd_q <= '0;
            wd_cnt   <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                src1_q <= in_src1;
                src2_q <= in_src2;
                op_q   <= in_op;
                rd_q   <= in_rd;
            end
            if (state == S_WAIT && m_out_valid && !flush) begin
                data_q   <= result_sel;
                out_rd_q <= rd_q;
            end
            // Counter saturates at WDOG so a long stall cannot wrap it.
            if (state == S_REQ && state_nx == S_WAIT) begin
                wd_cnt <= '0;
            end else if (state == S_WAIT && wd_cnt != WD_MAX) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (WDOG != 0 && state == S_WAIT && wd_cnt == WD_MAX - 1'b1) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: doc/mul_issue_ctrl.md
Name: mul_issue_ctrl

Overview:
- Requester-side front end for the handshake multiplier (mul_valid/mul_ready in, out_valid/result_hi/result_lo out).
- Accepts RISC-V M-extension multiply ops from EXU, maps each op to the multiplier's mulw/mul_signed controls, and drives and holds the request.
- Captures the result, selects hi/lo/sign-extended word, and presents it to writeback with a valid/ready handshake.
- Owns flush propagation and stale-result rejection.

Parameters:
- XLEN, 64, operand/result width.
- TAG_W, 5, width of the rd tag carried alongside the op.
- WDOG, 255, max cycles in WAIT before err asserts; 0 disables.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  cancel current op, any state.
- in_valid  in  1  EXU op valid.
- in_ready  out  1  controller can accept op.
- in_op  in  3  0=MUL 1=MULH 2=MULHSU 3=MULHU 4=MULW; 5-7 reserved.
- in_src1  in  XLEN  rs1.
- in_src2  in  XLEN  rs2.
- in_rd  in  TAG_W  destination tag.
- out_valid  out  1  result valid to WB.
- out_ready  in  1  WB accepts.
- out_data  out  XLEN  final rd value.
- out_rd  out  TAG_W  tag of result.
- err  out  1  sticky watchdog error.
- m_flush  out  1  to multiplier flush; equals flush (combinational).
- m_valid  out  1  to multiplier mul_valid.
- m_ready  in  1  from multiplier mul_ready.
- m_mulw  out  1  to multiplier mulw.
- m_signed  out  2  to multiplier mul_signed.
- m_multiplicand  out  XLEN  = latched src1.
- m_multiplier  out  XLEN  = latched src2.
- m_out_valid  in  1  from multiplier out_valid.
- m_hi  in  XLEN  from multiplier result_hi.
- m_lo  in  XLEN  from multiplier result_lo.

Behaviour:
- Reset (rst high at posedge): state=IDLE. in_ready, out_valid, m_valid, err are 0 the cycle after reset. out_data, out_rd and the latched operands are 0.
- States and transitions:
  - IDLE: in_ready = ~flush. On in_valid & in_ready, latch src1/src2/op/rd and go to REQ.
  - REQ: m_valid=1, operands and controls held stable. On m_ready=1, go to WAIT next cycle; m_valid drops in that same next cycle.
  - WAIT: m_valid=0. m_out_valid is sampled only in WAIT; the multiplier clears out_valid on acceptance, so any level seen here is fresh. On m_out_valid=1, load out_data/out_rd and go to DONE.
  - DONE: out_valid=1, out_data/out_rd stable. On out_ready=1, go to IDLE next cycle with out_valid=0.
- Back-to-back: in_ready is asserted only in IDLE. Minimum spacing is one idle cycle between ops.
- Op mapping (m_signed, m_mulw):
  - MUL: 11, 0.
  - MULH: 11, 0.
  - MULHSU: 10, 0 (src1 signed, src2 unsigned).
  - MULHU: 00, 0.
  - MULW: 11, 1.
  - Reserved ops behave as MUL.
- Result selection:
  - MUL: m_lo.
  - MULH/MULHSU/MULHU: m_hi.
  - MULW: sign-extend m_lo[31:0] to XLEN.
- Latency: in handshake at cycle N gives m_valid at N+1. With an immediately ready multiplier and k multiplier cycles, out_valid rises at N+3+k.
- Flush:
  - Highest priority. Any state goes to IDLE next cycle; m_valid and out_valid are 0 the next cycle.
  - An in_valid coinciding with flush is dropped.
  - A flush in DONE discards the unconsumed result.
  - After a flush, m_out_valid pulses are ignored; the multiplier may raise out_valid with a partial result when aborted mid-op.
- Watchdog:
  - Counter clears on entering WAIT and increments each WAIT cycle.
  - When it reaches WDOG, err sets and stays set until rst; flush does not clear it.
  - The controller keeps waiting after err sets.
- Simultaneous events:
  - m_ready and flush in REQ: flush wins, and the multiplier also aborts via m_flush.
  - out_ready and flush in DONE: go to IDLE. The result counts as not delivered, so the bench must not score it.
- Reset mid-op: rst overrides all states and flush, same values as the reset bullet above.

Test Plan:
- MUL: src1=3, src2=5, rd=7 -> out_data=0x000000000000000F, out_rd=7, m_signed=11, m_mulw=0.
- MULH/MULHSU/MULHU: src1=0xFFFFFFFFFFFFFFFF, src2=2 -> out_data = 0xFFFFFFFFFFFFFFFF (MULH), 0xFFFFFFFFFFFFFFFF (MULHSU), 0x0000000000000001 (MULHU).
- MULW: src1=0x000000007FFFFFFF, src2=2 -> m_mulw=1, out_data=0xFFFFFFFFFFFFFFFE.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and out_data stable, in_ready=0. out_ready=1 -> IDLE next cycle.
- Flush in WAIT, with a stale m_out_valid pulse injected 2 cycles later -> no out_valid. A following MUL 6*7 returns 42 only.
- Watchdog with WDOG=4: m_out_valid held 0 -> err=1 after 4 WAIT cycles; stays set through a flush; cleared by rst.
